// File: rtl/gelato_pkg.sv
// gelato_pkg: sizing helpers shared by the gelato FIFO slice.
// gelato_cnt_w gives the width of an occupancy counter holding 0..depth;
// gelato_ptr_w gives the width of an index over 0..depth-1 (never below 1 bit).
package gelato_pkg;

  function automatic int gelato_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int gelato_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/gelato_wrap_ctr.sv
// gelato_wrap_ctr: modulo-MAX counter with explicit wrap MAX-1 -> 0, so
// non-power-of-two ranges never pass through unused codes.
// clr has priority over en.
module gelato_wrap_ctr
  import gelato_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = gelato_ptr_w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // Counter register: clear, else advance with explicit wrap at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= (value == LAST) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/gelato_fifo_ring.sv
// gelato_fifo_ring: synchronous FIFO for any DEPTH >= 2, all entries usable,
// with occupancy count, almost-full/almost-empty compares, synchronous flush.
// Optional feature macro: GELATO_FIFO_BYPASS_EN (empty-bypass path din -> dout).
//
// Handshake: an element moves on an edge only when valid and ready are both
// high in the cycle before it; valid never depends on ready, and in the
// default build no output depends combinationally on din_valid or dout_ready.
module gelato_fifo_ring
  import gelato_pkg::*;
#(
  parameter int  DEPTH      = 4,
  parameter type T          = logic,
  parameter int  AFULL_LVL  = DEPTH - 1,
  parameter int  AEMPTY_LVL = 1,
  localparam int CNT_W      = gelato_cnt_w(DEPTH),
  localparam int PTR_W      = gelato_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             din_valid,
  input  T                 din,
  output logic             din_ready,
  output logic             dout_valid,
  output T                 dout,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LVL);

  // Storage is deliberately not reset; only pointers and count are.
  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             pass;
  logic             wr_en;
  logic             rd_en;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  // No write-through when full, even with a simultaneous pop.
  assign din_ready = !full && !flush;

`ifdef GELATO_FIFO_BYPASS_EN
  // When empty the producer's element is presented directly at the head.
  assign dout_valid = !flush && (empty ? din_valid : 1'b1);
  assign dout       = empty ? din : mem[rd_ptr];
  // Element consumed in the same cycle it arrived: never touches storage.
  assign pass       = empty && push && pop;
`else
  assign dout_valid = !flush && !empty;
  assign dout       = mem[rd_ptr];
  assign pass       = 1'b0;
`endif

  assign push  = din_valid && din_ready;
  assign pop   = dout_valid && dout_ready;
  assign wr_en = push && !pass;
  assign rd_en = pop && !pass;

  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  gelato_wrap_ctr #(.MAX(DEPTH)) u_wr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en),
    .clr   (flush),
    .value (wr_ptr)
  );

  gelato_wrap_ctr #(.MAX(DEPTH)) u_rd_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en),
    .clr   (flush),
    .value (rd_ptr)
  );

  // Occupancy: flush clears; otherwise +1 on write, -1 on read, hold on both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

`ifndef SYNTHESIS
  a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));
`endif

endmodule

// File: tb/tb_gelato_fifo_ring.sv
// tb_gelato_fifo_ring: directed and randomized checks of gelato_fifo_ring
// against a queue-based reference model. Two instances: DEPTH=3 (almost_full
// at full) and DEPTH=5 (default levels). Build with GELATO_FIFO_BYPASS_EN to
// exercise the bypass variant.
module tb_gelato_fifo_ring;
  typedef logic [7:0] byte_t;

`ifdef GELATO_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;

  logic       a_flush, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready, a_af, a_ae;
  byte_t      a_din, a_dout;
  logic [1:0] a_count;

  logic       b_flush, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready, b_af, b_ae;
  byte_t      b_din, b_dout;
  logic [2:0] b_count;

  gelato_fifo_ring #(.DEPTH(3), .T(byte_t), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .din_valid(a_din_valid), .din(a_din), .din_ready(a_din_ready),
    .dout_valid(a_dout_valid), .dout(a_dout), .dout_ready(a_dout_ready),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
  );

  gelato_fifo_ring #(.DEPTH(5), .T(byte_t)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .din_valid(b_din_valid), .din(b_din), .din_ready(b_din_ready),
    .dout_valid(b_dout_valid), .dout(b_dout), .dout_ready(b_dout_ready),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents as a queue plus the selected instance's levels.
  byte_t mq[$];
  int    m_depth;
  int    m_afull;
  int    m_aempty;
  int    sel;
  string tl;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %0h expected %0h", tl, tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a_flush = 1'b0; a_din_valid = 1'b0; a_din = '0; a_dout_ready = 1'b0;
    b_flush = 1'b0; b_din_valid = 1'b0; b_din = '0; b_dout_ready = 1'b0;
  endtask

  task automatic select(input int s);
    sel = s;
    mq.delete();
    if (s == 0) begin
      m_depth = 3; m_afull = 3; m_aempty = 1;
    end else begin
      m_depth = 5; m_afull = 4; m_aempty = 1;
    end
  endtask

  // One clock cycle on the selected instance: drive, check all outputs
  // against the model, report the handshakes, advance the model and clock.
  task automatic cyc(input bit fl, input bit dv, input byte_t d, input bit dr,
                     output bit pushed, output bit popped, output byte_t pd);
    bit    e_rdy, e_vld, pass;
    byte_t e_dout;
    int    sz;
    logic  o_rdy, o_vld, o_af, o_ae;
    byte_t o_dout;
    logic [31:0] o_cnt;
    if (sel == 0) begin
      a_flush = fl; a_din_valid = dv; a_din = d; a_dout_ready = dr;
    end else begin
      b_flush = fl; b_din_valid = dv; b_din = d; b_dout_ready = dr;
    end
    #1;
    if (sel == 0) begin
      o_rdy = a_din_ready; o_vld = a_dout_valid; o_dout = a_dout;
      o_cnt = 32'(a_count); o_af = a_af; o_ae = a_ae;
    end else begin
      o_rdy = b_din_ready; o_vld = b_dout_valid; o_dout = b_dout;
      o_cnt = 32'(b_count); o_af = b_af; o_ae = b_ae;
    end
    sz     = mq.size();
    e_rdy  = (sz != m_depth) && !fl;
    e_vld  = !fl && ((sz != 0) || (BYP && dv));
    e_dout = (sz != 0) ? mq[0] : d;
    chk("din_ready", 32'(o_rdy), 32'(e_rdy));
    chk("dout_valid", 32'(o_vld), 32'(e_vld));
    chk("count", o_cnt, 32'(sz));
    chk("almost_full", 32'(o_af), 32'(sz >= m_afull));
    chk("almost_empty", 32'(o_ae), 32'(sz <= m_aempty));
    if (e_vld) chk("dout", 32'(o_dout), 32'(e_dout));
    pushed = dv && e_rdy;
    popped = e_vld && dr;
    pd     = e_dout;
    pass   = BYP && (sz == 0) && pushed && popped;
    if (fl) begin
      mq.delete();
    end else if (!pass) begin
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  byte_t t1d [4];
  bit    pu, po;
  byte_t pd;
  int    k, rx, nxt, first_c, last_c;
  bit    pdv, fl, dr;
  byte_t pdata;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tl    = "reset";
    rst_n = 1'b0;
    idle_all();
    select(0);
    repeat (2) @(posedge clk);
    #1;
    chk("a_count", 32'(a_count), 0);
    chk("a_din_ready", 32'(a_din_ready), 1);
    chk("a_dout_valid", 32'(a_dout_valid), 0);
    chk("a_almost_full", 32'(a_af), 0);
    chk("a_almost_empty", 32'(a_ae), 1);
    chk("b_count", 32'(b_count), 0);
    rst_n = 1'b1;

    // Fill DEPTH=3 with a held producer and no consumer.
    tl = "fill3";
    t1d = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    k = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0, 1'b1, t1d[(k < 4) ? k : 3], 1'b0, pu, po, pd);
      if (pu) k++;
    end
    chk("accepted", 32'(k), 3);
    chk("count_full", 32'(a_count), 3);
    chk("din_ready_full", 32'(a_din_ready), 0);
    chk("almost_full", 32'(a_af), 1);
    tl = "drain3";
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, pu, po, pd);
      chk("popped", 32'(po), 1);
      chk("pop_data", 32'(pd), 32'(t1d[c]));
    end
    chk("count_empty", 32'(a_count), 0);

    // Full, push and pop offered together: only the pop is taken.
    tl = "full_pp";
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 8'(8'h11 + c), 1'b0, pu, po, pd);
    cyc(1'b0, 1'b1, 8'h14, 1'b1, pu, po, pd);
    chk("push_refused", 32'(pu), 0);
    chk("pop_taken", 32'(po), 1);
    chk("pop_data", 32'(pd), 32'h11);
    chk("count_after", 32'(a_count), 2);
    chk("din_ready_after", 32'(a_din_ready), 1);

    // Flush at count 2 with both handshakes offered.
    tl = "flush";
    cyc(1'b1, 1'b1, 8'h15, 1'b1, pu, po, pd);
    chk("push_refused", 32'(pu), 0);
    chk("pop_refused", 32'(po), 0);
    chk("count_after", 32'(a_count), 0);
    chk("dout_valid_after", 32'(a_dout_valid), 0);
    chk("almost_empty_after", 32'(a_ae), 1);

    // Asynchronous reset mid-burst at count 3.
    tl = "async_rst";
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 8'(8'h21 + c), 1'b0, pu, po, pd);
    chk("count_before", 32'(a_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("count", 32'(a_count), 0);
    chk("din_ready", 32'(a_din_ready), 1);
    chk("dout_valid", 32'(a_dout_valid), 0);
    chk("almost_full", 32'(a_af), 0);
    chk("almost_empty", 32'(a_ae), 1);
    mq.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 8'h05, 1'b0, pu, po, pd);
    chk("push_5", 32'(pu), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, pu, po, pd);
    chk("pop_5", 32'(po), 1);
    chk("data_5", 32'(pd), 32'h05);

    // Empty FIFO, element offered with consumer ready.
    tl = "bypass";
    cyc(1'b0, 1'b1, 8'h07, 1'b1, pu, po, pd);
`ifdef GELATO_FIFO_BYPASS_EN
    chk("same_cycle_pop", 32'(po), 1);
    chk("same_cycle_data", 32'(pd), 32'h07);
    chk("count_stays_0", 32'(a_count), 0);
`else
    chk("no_same_cycle_pop", 32'(po), 0);
    chk("valid_next", 32'(a_dout_valid), 1);
    chk("data_next", 32'(a_dout), 32'h07);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, pu, po, pd);
    chk("pop_next", 32'(po), 1);
`endif

    // DEPTH=5: continuous stream of 20 elements.
    tl = "stream5";
    select(1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, pu, po, pd);
    nxt = 0; rx = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (rx < 20) begin
        cyc(1'b0, nxt < 20, 8'(8'h40 + nxt), 1'b1, pu, po, pd);
        if (pu) nxt++;
        if (po) begin
          chk("order", 32'(pd), 32'(8'h40 + rx));
          if (rx == 0) first_c = c;
          last_c = c;
          rx++;
        end
      end
    end
    chk("received", 32'(rx), 20);
    chk("no_gaps", 32'(last_c - first_c), 19);

    // DEPTH=5: randomized traffic, filling phase then draining phase.
    tl = "random5";
    pdv = 1'b0; pdata = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pdv && ($urandom_range(0, 3) != 0)) begin
        pdv   = 1'b1;
        pdata = 8'($urandom_range(0, 255));
      end
      fl = ($urandom_range(0, 39) == 0);
      dr = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(fl, pdv, pdata, dr, pu, po, pd);
      if (pu) pdv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
